// File: rtl/complex_div_pkg.sv
// Shared fixed-point format constants and FSM encoding for the complex divider.
package complex_div_pkg;

    // Default word width and fractional bits (sign-magnitude, Q1.15 for N=16)
    localparam int CDIV_N = 16;
    localparam int CDIV_Q = CDIV_N - 1;

    // Largest representable magnitude; used when a quotient reaches 1.0
    localparam int CDIV_SAT_MAG = (2 ** (CDIV_N - 1)) - 1;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PROD = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/complex_div_qdiv_serial.sv
// Single-channel restoring divider: floor(|num| * 2^Q / den), one quotient
// bit per step, MSB first. The result is presented combinationally from the
// bit being decided this cycle, so the owner latches it on the final step.
module qdiv_serial
    import complex_div_pkg::*;
#(
    parameter int N = CDIV_N,
    parameter int Q = CDIV_Q
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_load,
    input  logic           i_step,
    input  logic           i_sign,
    input  logic [2*N-2:0] i_num,
    input  logic [2*N-2:0] i_den,
    output logic [N-1:0]   o_res,
    output logic           o_ovf
);

    // Room for both |num| << Q and den << (N-1)
    localparam int SH = (Q > N - 1) ? Q : N - 1;
    localparam int W  = 2 * N - 1 + SH;
    localparam logic [N-2:0] SAT_MAG = '1;

    logic [W-1:0] r_rem;
    logic [W-1:0] r_dsh;
    logic [N-2:0] r_q;
    logic         r_sign;

    logic         w_ge;
    logic [N-1:0] w_q_nxt;
    logic [N-2:0] w_mag;

    // Only N-1 bits are kept; the last bit comes straight from the compare.
    // A set integer bit implies quotient >= 1, so saturation is exact even
    // when the true quotient exceeds N bits.
    assign w_ge    = (r_rem >= r_dsh);
    assign w_q_nxt = {r_q, w_ge};
    assign o_ovf   = w_q_nxt[N-1];
    assign w_mag   = o_ovf ? SAT_MAG : w_q_nxt[N-2:0];
    assign o_res   = {r_sign & (|w_mag), w_mag};

    // Load operands, then shift-subtract once per step
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rem  <= '0;
            r_dsh  <= '0;
            r_q    <= '0;
            r_sign <= 1'b0;
        end else if (i_load) begin
            r_rem  <= {{SH{1'b0}}, i_num} << Q;
            r_dsh  <= {{SH{1'b0}}, i_den} << (N - 1);
            r_q    <= '0;
            r_sign <= i_sign;
        end else if (i_step) begin
            if (w_ge)
                r_rem <= r_rem - r_dsh;
            r_dsh <= r_dsh >> 1;
            r_q   <= w_q_nxt[N-2:0];
        end
    end

endmodule

// File: rtl/complex_div.sv
// Sign-magnitude complex divider (a+ib)/(c+id): full-precision products in
// one cycle, then two serial dividers for the real and imaginary parts.
module complex_div
    import complex_div_pkg::*;
#(
    parameter int N = CDIV_N,
    parameter int Q = N - 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [N-1:0] i_c,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_re,
    output logic [N-1:0] o_im,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_ovr,
    output logic         o_dbz
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_a, r_b, r_c, r_d;
    logic [N-1:0]  r_re, r_im;
    logic          r_done, r_ovr, r_dbz;

    // Magnitudes and signs; negative zero collapses to +0
    logic [N-2:0] w_ma, w_mb, w_mc, w_md;
    logic         w_sa, w_sb, w_sc, w_sd;

    assign w_ma = r_a[N-2:0];
    assign w_mb = r_b[N-2:0];
    assign w_mc = r_c[N-2:0];
    assign w_md = r_d[N-2:0];
    assign w_sa = r_a[N-1] & (|w_ma);
    assign w_sb = r_b[N-1] & (|w_mb);
    assign w_sc = r_c[N-1] & (|w_mc);
    assign w_sd = r_d[N-1] & (|w_md);

    // Full-width magnitude products
    logic [2*N-3:0] w_ac, w_bd, w_bc, w_ad, w_cc, w_dd;

    assign w_ac = {{(N-1){1'b0}}, w_ma} * {{(N-1){1'b0}}, w_mc};
    assign w_bd = {{(N-1){1'b0}}, w_mb} * {{(N-1){1'b0}}, w_md};
    assign w_bc = {{(N-1){1'b0}}, w_mb} * {{(N-1){1'b0}}, w_mc};
    assign w_ad = {{(N-1){1'b0}}, w_ma} * {{(N-1){1'b0}}, w_md};
    assign w_cc = {{(N-1){1'b0}}, w_mc} * {{(N-1){1'b0}}, w_mc};
    assign w_dd = {{(N-1){1'b0}}, w_md} * {{(N-1){1'b0}}, w_md};

    // Product as a two's-complement term wide enough for the sum of two
    function automatic logic [2*N-1:0] f_term(input logic s, input logic [2*N-3:0] p);
        logic [2*N-1:0] t;
        t = {2'b00, p};
        return s ? (~t + 1'b1) : t;
    endfunction

    logic [2*N-1:0] w_nre, w_nim;
    logic [2*N-2:0] w_mre, w_mim, w_den;

    assign w_nre = f_term(w_sa ^ w_sc, w_ac) + f_term(w_sb ^ w_sd, w_bd);
    assign w_nim = f_term(w_sb ^ w_sc, w_bc) + f_term(~(w_sa ^ w_sd), w_ad);
    // |sum| < 2^(2N-1), so negating the low bits alone is exact
    assign w_mre = w_nre[2*N-1] ? (~w_nre[2*N-2:0] + 1'b1) : w_nre[2*N-2:0];
    assign w_mim = w_nim[2*N-1] ? (~w_nim[2*N-2:0] + 1'b1) : w_nim[2*N-2:0];
    assign w_den = {1'b0, w_cc} + {1'b0, w_dd};

    logic         w_dbz, w_load, w_step;
    logic [N-1:0] w_re, w_im;
    logic         w_ovf_re, w_ovf_im;

    assign w_dbz  = (w_den == '0);
    assign w_load = (r_state == ST_PROD) && !w_dbz;
    assign w_step = (r_state == ST_DIV);

    qdiv_serial #(.N(N), .Q(Q)) u_div_re (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .i_step (w_step),
        .i_sign (w_nre[2*N-1]),
        .i_num  (w_mre),
        .i_den  (w_den),
        .o_res  (w_re),
        .o_ovf  (w_ovf_re)
    );

    qdiv_serial #(.N(N), .Q(Q)) u_div_im (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .i_step (w_step),
        .i_sign (w_nim[2*N-1]),
        .i_num  (w_mim),
        .i_den  (w_den),
        .o_res  (w_im),
        .o_ovf  (w_ovf_im)
    );

    // Controller: capture, product, N divide steps, one-cycle done
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_re    <= '0;
            r_im    <= '0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_c     <= i_c;
                        r_d     <= i_d;
                        r_state <= ST_PROD;
                    end
                end
                ST_PROD: begin
                    r_cnt <= '0;
                    if (w_dbz) begin
                        r_re    <= '0;
                        r_im    <= '0;
                        r_ovr   <= 1'b0;
                        r_dbz   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_re    <= w_re;
                        r_im    <= w_im;
                        r_ovr   <= w_ovf_re | w_ovf_im;
                        r_dbz   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_re   = r_re;
    assign o_im   = r_im;
    assign o_busy = (r_state != ST_IDLE);
    assign o_done = r_done;
    assign o_ovr  = r_ovr;
    assign o_dbz  = r_dbz;

endmodule
